// File: rtl/givens_pkg.sv
// Shared types and constants for the Givens rotation matrix store.
package givens_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_FRAC_W = 16;

  typedef enum logic {INIT, READY} givens_state_t;

  // Fixed-point 1.0 with frac_w fractional bits; callers truncate to their width.
  function automatic logic [63:0] one_val(input int frac_w);
    return 64'd1 << frac_w;
  endfunction

endpackage

// File: rtl/givens_tdp_ram.sv
// True dual-port read-first RAM with a two-stage registered read path and
// a matching valid pipeline per port.
module givens_tdp_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [AW-1:0]     a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [AW-1:0]     b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] a_q1, b_q1;
  logic              a_v1, b_v1;

  // NOTE: the array and first read stage have no reset so they map onto block RAM.
  // NOTE: non-blocking assignments make every read see the pre-write contents,
  // and the later port A write wins when both ports hit the same entry.
  always_ff @(posedge clk) begin
    if (a_en) a_q1 <= mem[a_addr];
    if (b_en) b_q1 <= mem[b_addr];
    if (b_en && b_we) mem[b_addr] <= b_wdata;
    if (a_en && a_we) mem[a_addr] <= a_wdata;
  end

  // Output stage only loads on a valid read so rdata holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_v1     <= 1'b0;
      b_v1     <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_v1     <= a_en & ~a_we;
      b_v1     <= b_en & ~b_we;
      a_rvalid <= a_v1;
      b_rvalid <= b_v1;
      if (a_v1) a_rdata <= a_q1;
      if (b_v1) b_rdata <= b_q1;
    end
  end

endmodule

// File: rtl/givens_matrix_store.sv
// N x N Givens rotation matrix store: self-initialises to identity, (row, col)
// addressed dual-port access with two-cycle read latency and collision flag.
module givens_matrix_store
  import givens_pkg::*;
#(
  parameter int N      = 2,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int FRAC_W = DEFAULT_FRAC_W,
  localparam int CW = (N > 1) ? $clog2(N) : 1
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_req,
  output logic              ready,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [CW-1:0]     a_row,
  input  logic [CW-1:0]     a_col,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [CW-1:0]     b_row,
  input  logic [CW-1:0]     b_col,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              wr_collision
);

  localparam int DEPTH = N * N;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATA_W-1:0] ONE = DATA_W'(one_val(FRAC_W));

  function automatic logic in_range(input logic [CW-1:0] row, input logic [CW-1:0] col);
    return (int'(row) < N) && (int'(col) < N);
  endfunction

  function automatic logic [AW-1:0] lin_addr(input logic [CW-1:0] row, input logic [CW-1:0] col);
    return AW'(int'(row) * N + int'(col));
  endfunction

  givens_state_t state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every output of this block is assigned a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      INIT: begin
        if (cnt == AW'(DEPTH - 1)) begin
          state_nxt = READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + AW'(1);
        end
      end
      READY: begin
        if (init_req) begin
          state_nxt = INIT;
          cnt_nxt   = '0;
        end
      end
      default: ;
    endcase
  end

  assign ready = (state == READY);

  // The cycle that accepts init_req drops both ports' requests.
  logic accept, a_ok, b_ok, is_diag;
  logic [AW-1:0] a_addr, b_addr;
  assign accept  = ready && !init_req;
  assign a_addr  = lin_addr(a_row, a_col);
  assign b_addr  = lin_addr(b_row, b_col);
  assign a_ok    = accept && a_en && in_range(a_row, a_col);
  assign b_ok    = accept && b_en && in_range(b_row, b_col);
  assign is_diag = (int'(cnt) % (N + 1)) == 0;

  logic              ram_a_en, ram_a_we;
  logic [AW-1:0]     ram_a_addr;
  logic [DATA_W-1:0] ram_a_wdata;

  // The identity writer owns port A while initialising.
  always_comb begin
    ram_a_en    = a_ok;
    ram_a_we    = a_we;
    ram_a_addr  = a_addr;
    ram_a_wdata = a_wdata;
    if (state == INIT) begin
      ram_a_en    = 1'b1;
      ram_a_we    = 1'b1;
      ram_a_addr  = cnt;
      ram_a_wdata = is_diag ? ONE : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_collision <= 1'b0;
    else        wr_collision <= a_ok && a_we && b_ok && b_we && (a_addr == b_addr);
  end

  givens_tdp_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_en    (ram_a_en),
    .a_we    (ram_a_we),
    .a_addr  (ram_a_addr),
    .a_wdata (ram_a_wdata),
    .a_rdata (a_rdata),
    .a_rvalid(a_rvalid),
    .b_en    (b_ok),
    .b_we    (b_we),
    .b_addr  (b_addr),
    .b_wdata (b_wdata),
    .b_rdata (b_rdata),
    .b_rvalid(b_rvalid)
  );

endmodule

// File: tb/tb_givens_matrix_store.sv
// Directed bench for givens_matrix_store: N=2 main instance plus N=4 and N=3
// instances for the identity sweep and out-of-range drop.
module tb_givens_matrix_store;

  localparam logic [31:0] ONE = 32'h0001_0000;

  typedef struct {
    logic [1:0]  row;
    logic [1:0]  col;
    logic [31:0] val;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // N = 2 instance
  logic        init_req, ready, wr_collision;
  logic        a_en, a_we, a_rvalid, b_en, b_we, b_rvalid;
  logic [0:0]  a_row, a_col, b_row, b_col;
  logic [31:0] a_wdata, a_rdata, b_wdata, b_rdata;

  // N = 4 and N = 3 instances share B coordinates; only B is exercised
  logic [1:0]  s_row, s_col;
  logic        s4_en, s4_ready, s4_a_rvalid, s4_b_rvalid, s4_coll;
  logic        s3_en, s3_ready, s3_a_rvalid, s3_b_rvalid, s3_coll;
  logic [31:0] s4_a_rdata, s4_b_rdata, s3_a_rdata, s3_b_rdata;

  givens_matrix_store #(.N(2), .DATA_W(32), .FRAC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .ready(ready),
    .a_en(a_en), .a_we(a_we), .a_row(a_row), .a_col(a_col), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_en(b_en), .b_we(b_we), .b_row(b_row), .b_col(b_col), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_rvalid(b_rvalid), .wr_collision(wr_collision)
  );

  givens_matrix_store #(.N(4), .DATA_W(32), .FRAC_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .init_req(1'b0), .ready(s4_ready),
    .a_en(1'b0), .a_we(1'b0), .a_row(2'b00), .a_col(2'b00), .a_wdata(32'h0),
    .a_rdata(s4_a_rdata), .a_rvalid(s4_a_rvalid),
    .b_en(s4_en), .b_we(1'b0), .b_row(s_row), .b_col(s_col), .b_wdata(32'h0),
    .b_rdata(s4_b_rdata), .b_rvalid(s4_b_rvalid), .wr_collision(s4_coll)
  );

  givens_matrix_store #(.N(3), .DATA_W(32), .FRAC_W(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .init_req(1'b0), .ready(s3_ready),
    .a_en(1'b0), .a_we(1'b0), .a_row(2'b00), .a_col(2'b00), .a_wdata(32'h0),
    .a_rdata(s3_a_rdata), .a_rvalid(s3_a_rvalid),
    .b_en(s3_en), .b_we(1'b0), .b_row(s_row), .b_col(s_col), .b_wdata(32'h0),
    .b_rdata(s3_b_rdata), .b_rvalid(s3_b_rvalid), .wr_collision(s3_coll)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single read: request sampled at edge t, result must be present at edge t+2.
  task automatic rd(input logic port_b, input logic [0:0] r, input logic [0:0] c,
                    input logic [31:0] exp, input string nm);
    if (port_b) begin b_en = 1'b1; b_we = 1'b0; b_row = r; b_col = c; end
    else        begin a_en = 1'b1; a_we = 1'b0; a_row = r; a_col = c; end
    step();
    a_en = 1'b0; b_en = 1'b0;
    @(negedge clk);
    check1({nm, " early"}, port_b ? b_rvalid : a_rvalid, 1'b0);
    @(posedge clk); @(negedge clk);
    check1({nm, " rvalid"}, port_b ? b_rvalid : a_rvalid, 1'b1);
    check({nm, " data"}, port_b ? b_rdata : a_rdata, exp);
    step();
  endtask

  task automatic a_wr(input logic [0:0] r, input logic [0:0] c, input logic [31:0] d);
    a_en = 1'b1; a_we = 1'b1; a_row = r; a_col = c; a_wdata = d;
    step();
    a_en = 1'b0; a_we = 1'b0;
  endtask

  // Port B read on the N=4 (n4=1) or N=3 instance; data must equal exp either
  // way (a dropped read leaves rdata holding its previous value).
  task automatic srd(input logic n4, input logic [1:0] r, input logic [1:0] c,
                     input logic exp_valid, input logic [31:0] exp, input string nm);
    s_row = r; s_col = c;
    if (n4) s4_en = 1'b1; else s3_en = 1'b1;
    step();
    s4_en = 1'b0; s3_en = 1'b0;
    @(posedge clk); @(negedge clk);
    check1({nm, " rvalid"}, n4 ? s4_b_rvalid : s3_b_rvalid, exp_valid);
    check({nm, " data"}, n4 ? s4_b_rdata : s3_b_rdata, exp);
    step();
  endtask

  task automatic wait_init_done(input string nm);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); @(negedge clk);
      check1($sformatf("%s ready edge %0d", nm, k), ready, (k == 4));
    end
  endtask

  vec_t id_tbl[4];
  vec_t wr_tbl[4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    id_tbl[0] = '{2'd0, 2'd0, ONE};
    id_tbl[1] = '{2'd0, 2'd1, 32'h0};
    id_tbl[2] = '{2'd1, 2'd0, 32'h0};
    id_tbl[3] = '{2'd1, 2'd1, ONE};
    wr_tbl[0] = '{2'd0, 2'd0, 32'h1234_5678};
    wr_tbl[1] = '{2'd0, 2'd1, 32'h8000_0001};
    wr_tbl[2] = '{2'd1, 2'd0, 32'hDEAD_BEEF};
    wr_tbl[3] = '{2'd1, 2'd1, 32'h7FFF_FFFF};

    rst_n = 1'b0; init_req = 1'b0;
    a_en = 1'b0; a_we = 1'b0; a_row = '0; a_col = '0; a_wdata = '0;
    b_en = 1'b0; b_we = 1'b0; b_row = '0; b_col = '0; b_wdata = '0;
    s_row = '0; s_col = '0; s4_en = 1'b0; s3_en = 1'b0;

    // Reset values and INIT length
    repeat (3) @(posedge clk);
    @(negedge clk);
    check1("rst ready", ready, 1'b0);
    check1("rst a_rvalid", a_rvalid, 1'b0);
    check1("rst b_rvalid", b_rvalid, 1'b0);
    check1("rst collision", wr_collision, 1'b0);
    check("rst a_rdata", a_rdata, 32'h0);
    check("rst b_rdata", b_rdata, 32'h0);
    step();
    rst_n = 1'b1;
    wait_init_done("init");

    for (int i = 0; i < 4; i++)
      rd(1'b1, id_tbl[i].row[0], id_tbl[i].col[0], id_tbl[i].val, $sformatf("identity B %0d", i));

    // Back-to-back reads of a freshly written entry
    a_wr(1'b0, 1'b1, 32'hFFFF_8000);
    b_en = 1'b1; b_we = 1'b0; b_row = 1'b0; b_col = 1'b1;
    step();
    @(negedge clk); check1("tp lat0", b_rvalid, 1'b0);
    step();
    @(negedge clk); check1("tp v0", b_rvalid, 1'b1); check("tp d0", b_rdata, 32'hFFFF_8000);
    step();
    b_en = 1'b0;
    @(negedge clk); check1("tp v1", b_rvalid, 1'b1); check("tp d1", b_rdata, 32'hFFFF_8000);
    step();
    @(negedge clk); check1("tp v2", b_rvalid, 1'b1); check("tp d2", b_rdata, 32'hFFFF_8000);
    @(posedge clk); @(negedge clk);
    check1("tp end", b_rvalid, 1'b0);
    check("tp hold", b_rdata, 32'hFFFF_8000);
    step();

    // Read-first: B reads (1,1) while A writes it
    a_en = 1'b1; a_we = 1'b1; a_row = 1'b1; a_col = 1'b1; a_wdata = 32'h5;
    b_en = 1'b1; b_we = 1'b0; b_row = 1'b1; b_col = 1'b1;
    step();
    a_en = 1'b0; a_we = 1'b0;
    @(negedge clk); check1("rdw no collision", wr_collision, 1'b0);
    step();
    b_en = 1'b0;
    @(negedge clk); check1("rdw v old", b_rvalid, 1'b1); check("rdw old", b_rdata, ONE);
    @(posedge clk); @(negedge clk);
    check1("rdw v new", b_rvalid, 1'b1); check("rdw new", b_rdata, 32'h5);
    step();

    // Same-entry write on both ports
    a_en = 1'b1; a_we = 1'b1; a_row = 1'b1; a_col = 1'b0; a_wdata = 32'h11;
    b_en = 1'b1; b_we = 1'b1; b_row = 1'b1; b_col = 1'b0; b_wdata = 32'h22;
    step();
    a_en = 1'b0; a_we = 1'b0; b_en = 1'b0; b_we = 1'b0;
    @(negedge clk); check1("coll pulse", wr_collision, 1'b1);
    @(posedge clk); @(negedge clk); check1("coll clear", wr_collision, 1'b0);
    step();
    rd(1'b1, 1'b1, 1'b0, 32'h11, "coll winner");

    // Table: write every entry on A, read back on A
    for (int i = 0; i < 4; i++) a_wr(wr_tbl[i].row[0], wr_tbl[i].col[0], wr_tbl[i].val);
    for (int i = 0; i < 4; i++)
      rd(1'b0, wr_tbl[i].row[0], wr_tbl[i].col[0], wr_tbl[i].val, $sformatf("tbl A %0d", i));

    // Re-init with a B read in flight; A requests during the window are ignored
    b_en = 1'b1; b_we = 1'b0; b_row = 1'b0; b_col = 1'b0;
    step();
    b_en = 1'b0; init_req = 1'b1;
    a_en = 1'b1; a_we = 1'b0; a_row = 1'b1; a_col = 1'b1;
    step();
    init_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check1("reinit inflight v", b_rvalid, 1'b1);
        check("reinit inflight d", b_rdata, wr_tbl[0].val);
      end
      if (k == 1) check1("reinit inflight once", b_rvalid, 1'b0);
      check1($sformatf("reinit a_rvalid %0d", k), a_rvalid, 1'b0);
      check1($sformatf("reinit ready %0d", k), ready, (k >= 4));
      step();
      if (k == 3) a_en = 1'b0;
    end
    for (int i = 0; i < 4; i++)
      rd(1'b0, id_tbl[i].row[0], id_tbl[i].col[0], id_tbl[i].val, $sformatf("reinit id A %0d", i));

    // Reset with a read in flight, then reset again in the middle of INIT
    b_en = 1'b1; b_we = 1'b0; b_row = 1'b1; b_col = 1'b1;
    step();
    b_en = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check1("rst inflight b_rvalid", b_rvalid, 1'b0);
    check("rst a_rdata cleared", a_rdata, 32'h0);
    step();
    rst_n = 1'b1;
    step(); step();
    rst_n = 1'b0;
    @(negedge clk);
    check1("midinit ready", ready, 1'b0);
    check1("midinit a_rvalid", a_rvalid, 1'b0);
    check1("midinit b_rvalid", b_rvalid, 1'b0);
    check1("midinit collision", wr_collision, 1'b0);
    check("midinit b_rdata", b_rdata, 32'h0);
    step(); step();
    rst_n = 1'b1;
    wait_init_done("restart");
    for (int i = 0; i < 4; i++)
      rd(1'b1, id_tbl[i].row[0], id_tbl[i].col[0], id_tbl[i].val, $sformatf("restart id B %0d", i));

    // N = 4 identity
    for (int w = 0; w < 40 && !s4_ready; w++) step();
    check1("n4 ready", s4_ready, 1'b1);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        srd(1'b1, 2'(r), 2'(c), 1'b1, (r == c) ? ONE : 32'h0, $sformatf("n4 (%0d,%0d)", r, c));

    // N = 3 identity and out-of-range drops
    check1("n3 ready", s3_ready, 1'b1);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        srd(1'b0, 2'(r), 2'(c), 1'b1, (r == c) ? ONE : 32'h0, $sformatf("n3 (%0d,%0d)", r, c));
    srd(1'b0, 2'd3, 2'd0, 1'b0, ONE, "n3 row3 drop");
    srd(1'b0, 2'd0, 2'd3, 1'b0, ONE, "n3 col3 drop");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/givens_matrix_store.md
# givens_matrix_store

Parametrised dual-port store for an N×N fixed-point Givens rotation matrix, replacing the fixed 4-entry, 32-bit BRAM wrapper in the PCA datapath. It self-initialises to the identity matrix after reset or on request, addresses entries by (row, col), and returns read data with a fixed two-cycle latency and a valid strobe. Port A serves the rotation-angle generator (matrix writer). Port B serves the rotation/update engine.

## Interface
Parameters:
- N, 2, matrix dimension; depth = N*N entries
- DATA_W, 32, entry width (two's-complement fixed point)
- FRAC_W, 16, fractional bits; identity diagonal value ONE = 1 << FRAC_W

Ports:
- clk  in  1  single clock for both ports
- rst_n  in  1  asynchronous, active-low reset
- init_req  in  1  pulse: rewrite the whole matrix to identity
- ready  out  1  high when ports accept requests
- a_en  in  1  port A request
- a_we  in  1  port A write (1) / read (0)
- a_row, a_col  in  $clog2(N) each  port A entry coordinates
- a_wdata  in  DATA_W  port A write data
- a_rdata  out  DATA_W  port A read data
- a_rvalid  out  1  port A read data valid
- b_* : identical set for port B
- wr_collision  out  1  pulse: both ports wrote the same entry

## Operation
- Linear address is row*N + col. A request with row ≥ N or col ≥ N is dropped: no write, no rvalid.
- FSM states: INIT, READY.
- INIT:
  - An address counter walks 0..N*N-1, one entry per cycle.
  - Each entry is written ONE if row == col, else 0.
  - ready = 0. Port requests are ignored and produce no rvalid.
  - After the last entry the FSM moves to READY. INIT lasts exactly N*N cycles.
- READY:
  - ready = 1. Each port independently performs one read or write per cycle when en = 1.
  - init_req = 1 moves the FSM to INIT with the counter at 0, and that cycle's port requests are ignored.
  - init_req during INIT is ignored; the counter is not restarted.
- Read-first semantics on both ports: a read of an entry written in the same cycle, by either port, returns the old contents.
- Both ports write the same entry in the same cycle: port A's data is stored, port B's write is lost, and wr_collision pulses for one cycle at t+1. Write on one port plus read on the other of the same entry is not a collision.
- Reads already in flight when init_req is accepted complete normally and return pre-init data.

## Timing
- Reset values: ready = 0, a_rdata = b_rdata = 0, a_rvalid = b_rvalid = 0, wr_collision = 0, FSM = INIT, counter = 0. The memory array itself is not reset.
- Reset asserted mid-operation clears all in-flight rvalid and restarts INIT on deassertion.
- Read latency is 2 cycles: a request at edge t gives rdata and rvalid = 1 at edge t+2, with rvalid high for exactly one cycle per read.
- Full throughput: one read per port per cycle, back-to-back, so rvalid may stay high continuously.
- rdata holds its last value while rvalid = 0.
- Writes are visible to reads issued at t+1 or later.
- The first cycle with ready = 1 is N*N cycles after rst_n deasserts, or N*N cycles after the cycle init_req was accepted.

## Structure
- Package givens_pkg holds:
  - default DATA_W and FRAC_W;
  - function one_val(FRAC_W);
  - typedef enum logic {INIT, READY} givens_state_t.
- Sub-module givens_tdp_ram (DATA_W, DEPTH):
  - behavioural true dual-port, read-first RAM, inferable as block RAM;
  - two output register stages per port;
  - valid pipeline alongside the data stages.
- The top module contains:
  - FSM and init counter;
  - coordinate-to-address conversion and range check;
  - port muxing (the init writer owns port A during INIT);
  - collision detection.

## Test plan
- Identity after reset (N=2, DATA_W=32, FRAC_W=16): release rst_n, wait 4 cycles until ready = 1, read all 4 entries on B. Expect 0x00010000, 0, 0, 0x00010000, each exactly 2 cycles after its request.
- Read latency and throughput: A writes (0,1) = 0xFFFF8000. B then reads (0,1) on 3 consecutive cycles. Expect rvalid high for 3 consecutive cycles, each with 0xFFFF8000.
- Write collision: A writes (1,0) = 0x11, B writes (1,0) = 0x22 in the same cycle. Expect wr_collision pulse at t+1, and a later read returns 0x11.
- Read-during-write: (1,1) holds 0x00010000. A writes 0x5, B reads (1,1) in the same cycle. Expect B to get 0x00010000; a read the next cycle returns 0x5.
- Re-init with reads in flight: write non-identity data, issue a B read, then pulse init_req next cycle. Expect the pending read returns old data, ready = 0 for 4 cycles, requests in that window give no rvalid, and the matrix then reads as identity.
- Reset mid-INIT and parameter sweep: assert rst_n low during INIT, expect all outputs 0 and full INIT restart after release. Repeat the identity check at N=4 (16-cycle INIT) and at N=3 (expect reads at row = 3 dropped, no rvalid).
